// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command encodings {CS#,RAS#,CAS#,WE#} and write-sequencer state encoding.
package sdram_pkg;
    localparam logic [3:0] CMD_NOP      = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE   = 4'b0011;
    localparam logic [3:0] CMD_WRITE    = 4'b0100;
    localparam logic [3:0] CMD_B_STOP   = 4'b0110;
    localparam logic [3:0] CMD_P_CHARGE = 4'b0010;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_ACT  = 4'd1,
        S_TRCD = 4'd2,
        S_WRITE = 4'd3,
        S_DATA = 4'd4,
        S_TWR  = 4'd5,
        S_PRE  = 4'd6,
        S_TRP  = 4'd7,
        S_END  = 4'd8
    } state_t;
endpackage

// File: rtl/sdram_write_burst_if.sv
// sdram_write_burst_if: arbiter-side request/beat handshake plus SDRAM command/data bus.
// master drives init_end, wr_en, wr_addr, wr_burst_len, wr_data; slave (the sequencer)
// drives wr_ack, wr_end, write_cmd, write_ba, write_addr, wr_sdram_en, wr_sdram_data.
interface sdram_write_burst_if #(
    parameter int DATA_W = 32,
    parameter int BA_W   = 2,
    parameter int ROW_W  = 11,
    parameter int COL_W  = 8,
    parameter int LEN_W  = 10
);
    logic                        init_end;
    logic                        wr_en;
    logic [BA_W+ROW_W+COL_W-1:0] wr_addr;
    logic [LEN_W-1:0]            wr_burst_len;
    logic [DATA_W-1:0]           wr_data;
    logic                        wr_ack;
    logic                        wr_end;
    logic [3:0]                  write_cmd;
    logic [BA_W-1:0]             write_ba;
    logic [ROW_W-1:0]            write_addr;
    logic                        wr_sdram_en;
    logic [DATA_W-1:0]           wr_sdram_data;

    modport master (
        output init_end, wr_en, wr_addr, wr_burst_len, wr_data,
        input  wr_ack, wr_end, write_cmd, write_ba, write_addr, wr_sdram_en, wr_sdram_data
    );
    modport slave (
        input  init_end, wr_en, wr_addr, wr_burst_len, wr_data,
        output wr_ack, wr_end, write_cmd, write_ba, write_addr, wr_sdram_en, wr_sdram_data
    );
endinterface

// File: rtl/sdram_seg_calc.sv
// sdram_seg_calc: beats that fit in the current page, and the following {bank,row}.
// Ports: cur_addr {ba,row,col} and remaining in; seg_len and next_bank_row out.
module sdram_seg_calc #(
    parameter int BA_W  = 2,
    parameter int ROW_W = 11,
    parameter int COL_W = 8,
    parameter int LEN_W = 10
) (
    input  logic [BA_W+ROW_W+COL_W-1:0] cur_addr,
    input  logic [LEN_W-1:0]            remaining,
    output logic [LEN_W-1:0]            seg_len,
    output logic [BA_W+ROW_W-1:0]       next_bank_row
);
    // Wide enough for both the full page size (2^COL_W) and any remaining length.
    localparam int SW = (LEN_W > COL_W ? LEN_W : COL_W) + 1;
    logic [SW-1:0] room;
    always_comb begin
        room          = (SW'(1) << COL_W) - SW'(cur_addr[COL_W-1:0]);
        seg_len       = (SW'(remaining) < room) ? remaining : LEN_W'(room);
        // Bank and row increment together, so the last row of bank 3 wraps to bank 0 row 0.
        next_bank_row = cur_addr[BA_W+ROW_W+COL_W-1:COL_W] + (BA_W+ROW_W)'(1);
    end
endmodule

// File: rtl/sdram_write_burst.sv
// sdram_write_burst: SDRAM burst-write sequencer with page-crossing split and tWR.
// Ports: sys_clk, sys_rst_n (sync, active low), bus (slave side of sdram_write_burst_if).
module sdram_write_burst
    import sdram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int BA_W     = 2,
    parameter int ROW_W    = 11,
    parameter int COL_W    = 8,
    parameter int LEN_W    = 10,
    parameter int AP_BIT   = 10,
    parameter int TRCD_CLK = 2,
    parameter int TWR_CLK  = 2,
    parameter int TRP_CLK  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    sdram_write_burst_if.slave bus
);
    localparam int AW = BA_W + ROW_W + COL_W;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d, remaining_q, remaining_d, seg_len;
    logic [AW-1:0]        cur_addr_q, cur_addr_d;
    logic [BA_W+ROW_W-1:0] next_bank_row;
    logic [3:0]           cmd_q, cmd_d;
    logic [BA_W-1:0]      ba_q, ba_d, cur_ba;
    logic [ROW_W-1:0]     addr_q, addr_d, cur_row;
    logic [COL_W-1:0]     cur_col;
    logic                 en_q, en_d, ack;

    assign cur_ba  = cur_addr_q[AW-1 -: BA_W];
    assign cur_row = cur_addr_q[COL_W +: ROW_W];
    assign cur_col = cur_addr_q[COL_W-1:0];

    sdram_seg_calc #(.BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W), .LEN_W(LEN_W)) u_seg (
        .cur_addr      (cur_addr_q),
        .remaining     (remaining_q),
        .seg_len       (seg_len),
        .next_bank_row (next_bank_row)
    );

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        cmd_d       = CMD_NOP;
        ba_d        = '1;
        addr_d      = '1;
        case (state_q)
            S_IDLE: if (bus.wr_en && bus.init_end && bus.wr_burst_len != '0) begin
                state_d     = S_ACT;
                cur_addr_d  = bus.wr_addr;
                remaining_d = bus.wr_burst_len;
            end
            S_ACT: begin
                state_d = S_TRCD;
                cmd_d   = CMD_ACTIVE;
                ba_d    = cur_ba;
                addr_d  = cur_row;
            end
            S_TRCD: if (cnt_q == LEN_W'(TRCD_CLK)) state_d = S_WRITE;
            S_WRITE: begin
                state_d = S_DATA;
                cmd_d   = CMD_WRITE;
                ba_d    = cur_ba;
                addr_d  = ROW_W'(cur_col);
            end
            S_DATA: if (cnt_q == seg_len - LEN_W'(1)) begin
                state_d = S_TWR;
                cmd_d   = CMD_B_STOP;
            end
            S_TWR: if (cnt_q == LEN_W'(TWR_CLK - 1)) state_d = S_PRE;
            S_PRE: begin
                state_d = S_TRP;
                cmd_d   = CMD_P_CHARGE;
                addr_d  = ROW_W'(1) << AP_BIT;
            end
            S_TRP: if (cnt_q == LEN_W'(TRP_CLK)) begin
                if (remaining_q != seg_len) begin
                    state_d     = S_ACT;
                    remaining_d = remaining_q - seg_len;
                    cur_addr_d  = {next_bank_row, COL_W'(0)};
                end else begin
                    state_d = S_END;
                end
            end
            S_END: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + LEN_W'(1);
        // WRITE supplies the first beat, so DATA acks one fewer: seg_len acks in total.
        ack  = (state_q == S_WRITE) ||
               (state_q == S_DATA && (LEN_W+1)'(cnt_q) + (LEN_W+1)'(2) <= (LEN_W+1)'(seg_len));
        en_d = ack;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            cmd_q       <= CMD_NOP;
            ba_q        <= '1;
            addr_q      <= '1;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            cmd_q       <= cmd_d;
            ba_q        <= ba_d;
            addr_q      <= addr_d;
            en_q        <= en_d;
        end
    end

    assign bus.wr_ack        = ack;
    assign bus.wr_end        = (state_q == S_END);
    assign bus.write_cmd     = cmd_q;
    assign bus.write_ba      = ba_q;
    assign bus.write_addr    = addr_q;
    assign bus.wr_sdram_en   = en_q;
    assign bus.wr_sdram_data = en_q ? bus.wr_data : '0;
endmodule
